// File: rtl/sobel_window_filter.sv
// ---------------------------------------------------------------------------
// sobel_window_filter
//
// Takes 3x3 pixel windows from the window generator. For each accepted
// window it computes a Sobel gradient magnitude in a three-stage pipeline.
// It also counts the windows accepted in a frame and pulses 'complete' once
// the last result has left the pipeline.
//
// Configuration macro:
//   SOBEL_THRESHOLD_EN  When defined, the output pixel is binarised against
//                       'threshold': 255 if the saturated magnitude is at
//                       least 'threshold', otherwise 0.
//                       When undefined, 'threshold' is unused and pix_out is
//                       the saturated magnitude.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   reset      synchronous, active-high reset
//   start      one-cycle pulse; begins a frame when idle
//   win_valid  in1..in9 carry a valid window this cycle
//   in1..in9   window pixels, row-major, unsigned 8-bit
//   threshold  binarisation level (SOBEL_THRESHOLD_EN builds only)
//   pix_out    filtered pixel; holds its value while pix_valid is low
//   pix_valid  pix_out carries a new result this cycle
//   busy       frame in progress (RUN or DRAIN)
//   complete   one-cycle pulse at the end of a frame
//   pix_count  windows accepted in the current or last frame
// ---------------------------------------------------------------------------
module sobel_window_filter #(
    parameter int NUM_PIX = 100,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             win_valid,
    input  logic [7:0]       in1,
    input  logic [7:0]       in2,
    input  logic [7:0]       in3,
    input  logic [7:0]       in4,
    input  logic [7:0]       in5,
    input  logic [7:0]       in6,
    input  logic [7:0]       in7,
    input  logic [7:0]       in8,
    input  logic [7:0]       in9,
    input  logic [7:0]       threshold,
    output logic [7:0]       pix_out,
    output logic             pix_valid,
    output logic             busy,
    output logic             complete,
    output logic [CNT_W-1:0] pix_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Count value held just before the final window of a frame is accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIX - 1);

    // Magnitude of a signed 11-bit gradient; |-1020..1020| fits in 10 bits.
    function automatic logic [9:0] abs_grad(input logic signed [10:0] g);
        logic [10:0] mag;
        if (g[10]) begin
            mag = 11'd0 - 11'(g);
        end else begin
            mag = 11'(g);
        end
        return mag[9:0];
    endfunction

    // Clamp an 11-bit magnitude sum to the 8-bit pixel range.
    function automatic logic [7:0] sat8(input logic [10:0] s);
        logic [7:0] r;
        if (s > 11'd255) begin
            r = 8'd255;
        end else begin
            r = s[7:0];
        end
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [10:0]       gx_q, gx_d, gy_q, gy_d;
    logic [9:0]               ax_q, ax_d, ay_q, ay_d;
    logic [7:0]               pix_out_q, pix_out_d;
    logic                     busy_q, busy_d, complete_q, complete_d;

    logic                     accept_s;
    logic [9:0]               pos_x_s, neg_x_s, pos_y_s, neg_y_s;
    logic [10:0]              sum_s;
    logic [7:0]               mag_s, res_s;
    logic                     unused_s;

    // The centre pixel carries no weight in either Sobel kernel.
`ifdef SOBEL_THRESHOLD_EN
    assign unused_s = ^in5;
`else
    assign unused_s = ^{in5, threshold};
`endif

    assign accept_s = (state_q == ST_RUN) && win_valid;

    // Pipeline datapath: gradients (S1), magnitudes (S2), combined pixel (S3).
    always_comb begin
        pos_x_s = {2'b00, in3} + {1'b0, in6, 1'b0} + {2'b00, in9};
        neg_x_s = {2'b00, in1} + {1'b0, in4, 1'b0} + {2'b00, in7};
        pos_y_s = {2'b00, in7} + {1'b0, in8, 1'b0} + {2'b00, in9};
        neg_y_s = {2'b00, in1} + {1'b0, in2, 1'b0} + {2'b00, in3};
        gx_d    = $signed({1'b0, pos_x_s}) - $signed({1'b0, neg_x_s});
        gy_d    = $signed({1'b0, pos_y_s}) - $signed({1'b0, neg_y_s});
        ax_d    = abs_grad(gx_q);
        ay_d    = abs_grad(gy_q);
        sum_s   = {1'b0, ax_q} + {1'b0, ay_q};
        mag_s   = sat8(sum_s);
`ifdef SOBEL_THRESHOLD_EN
        if (mag_s >= threshold) begin
            res_s = 8'd255;
        end else begin
            res_s = 8'd0;
        end
`else
        res_s = mag_s;
`endif
        // pix_out only changes when a result leaves the last stage.
        if (v2_q) begin
            pix_out_d = res_s;
        end else begin
            pix_out_d = pix_out_q;
        end
        v1_d = accept_s;
        v2_d = v1_q;
        v3_d = v2_q;
    end

    // Window counter: cleared by a start that opens a frame, bumped per accepted window.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (cnt_q == LAST_CNT)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave once the pipeline will be empty after this edge, so
                // complete lands one cycle after the final pix_valid.
                if (!(v1_d || v2_d || v3_d)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so busy/complete leave the block registered.
    always_comb begin
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        complete_d = (state_d == ST_DONE);
    end

    // All state, pipeline and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            gx_q       <= 11'sd0;
            gy_q       <= 11'sd0;
            ax_q       <= 10'd0;
            ay_q       <= 10'd0;
            pix_out_q  <= 8'd0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            pix_out_q  <= pix_out_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
        end
    end

    assign pix_out   = pix_out_q;
    assign pix_valid = v3_q;
    assign busy      = busy_q;
    assign complete  = complete_q;
    assign pix_count = cnt_q;

endmodule

// File: tb/tb_sobel_window_filter.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_filter
//
// Two instances share the window inputs: instance 0 uses NUM_PIX=1 and
// instance 1 uses NUM_PIX=4. Each has its own start. A behavioural model
// uses convolution kernels and a list of pending results with due cycles.
// Every cycle, on the falling edge, it predicts each instance's outputs and
// compares them. Directed steps also check hand-computed literal values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sobel_window_filter;

    localparam int KX[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int KY[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

`ifdef SOBEL_THRESHOLD_EN
    localparam int EXP_FLAT = 0;
    localparam int EXP_VERT = 255;
    localparam int EXP_SMALL = 255;
    localparam int EXP_NINE = 0;
`else
    localparam int EXP_FLAT = 0;
    localparam int EXP_VERT = 255;
    localparam int EXP_SMALL = 20;
    localparam int EXP_NINE = 18;
`endif

    logic        clk;
    logic        reset;
    logic        start1, start4;
    logic        win_valid;
    logic [7:0]  win [9];
    logic [7:0]  thr;
    logic [7:0]  po [2];
    logic        pv [2];
    logic        bz [2];
    logic        cp [2];
    logic [15:0] pc [2];

    int cyc;
    int n_checks;
    int n_fail;
    bit chk_en;

    sobel_window_filter #(.NUM_PIX(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .win_valid(win_valid),
        .in1(win[0]), .in2(win[1]), .in3(win[2]), .in4(win[3]), .in5(win[4]),
        .in6(win[5]), .in7(win[6]), .in8(win[7]), .in9(win[8]),
        .threshold(thr), .pix_out(po[0]), .pix_valid(pv[0]), .busy(bz[0]),
        .complete(cp[0]), .pix_count(pc[0])
    );

    sobel_window_filter #(.NUM_PIX(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .win_valid(win_valid),
        .in1(win[0]), .in2(win[1]), .in3(win[2]), .in4(win[3]), .in5(win[4]),
        .in6(win[5]), .in7(win[6]), .in8(win[7]), .in9(win[8]),
        .threshold(thr), .pix_out(po[1]), .pix_valid(pv[1]), .busy(bz[1]),
        .complete(cp[1]), .pix_count(pc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference Sobel: kernel dot products, |Gx|+|Gy|, saturate, optional binarise.
    function automatic int sobel_ref(input int p1, input int p2, input int p3,
                                     input int p4, input int p5, input int p6,
                                     input int p7, input int p8, input int p9);
        int w[9];
        int gx, gy, m;
        w  = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
        gx = 0;
        gy = 0;
        for (int i = 0; i < 9; i++) begin
            gx += KX[i] * w[i];
            gy += KY[i] * w[i];
        end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
        m = (m >= int'(thr)) ? 255 : 0;
`endif
        return m;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%0d required=%0d",
                     name, k, cyc, act, exp);
        end
    endtask

    // Model state, one slot per instance (0: NUM_PIX=1, 1: NUM_PIX=4).
    typedef struct {int k; int due; int val;} exp_t;
    exp_t pend[$];
    int   m_cnt [2];
    bit   m_inframe [2];
    bit   m_accept [2];
    int   m_comp_due [2];
    int   m_out [2];
    int   mn;
    bit   m_ev, m_idle, m_st;
    exp_t e;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_inframe[k] = 1'b0; m_accept[k] = 1'b0;
            m_comp_due[k] = -10; m_out[k] = 0;
        end
    end

    // Compare the current outputs, then advance the model over the next edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            mn = cyc;
            for (int k = 0; k < 2; k++) begin
                m_ev = 1'b0;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].k == k && pend[i].due == mn) begin
                        m_ev = 1'b1;
                        m_out[k] = pend[i].val;
                        pend.delete(i);
                        break;
                    end
                end
                if (chk_en) begin
                    chk("pix_valid", k, 32'(pv[k]), 32'(m_ev));
                    chk("pix_out", k, 32'(po[k]), 32'(m_out[k]));
                    chk("pix_count", k, 32'(pc[k]), 32'(m_cnt[k]));
                    chk("busy", k, 32'(bz[k]), 32'(m_inframe[k]));
                    chk("complete", k, 32'(cp[k]), 32'(mn == m_comp_due[k]));
                end
                m_st = (k == 0) ? start1 : start4;
                if (reset) begin
                    m_cnt[k] = 0; m_inframe[k] = 1'b0; m_accept[k] = 1'b0;
                    m_comp_due[k] = -10; m_out[k] = 0;
                    for (int i = pend.size() - 1; i >= 0; i--) begin
                        if (pend[i].k == k) pend.delete(i);
                    end
                end else begin
                    m_idle = !m_inframe[k] && (m_comp_due[k] != mn);
                    if (m_accept[k] && win_valid) begin
                        e.k   = k;
                        e.due = mn + 3;
                        e.val = sobel_ref(win[0], win[1], win[2], win[3], win[4],
                                          win[5], win[6], win[7], win[8]);
                        pend.push_back(e);
                        m_cnt[k]++;
                        if (m_cnt[k] == ((k == 0) ? 1 : 4)) begin
                            m_accept[k]   = 1'b0;
                            m_comp_due[k] = mn + 4;
                        end
                    end
                    if (m_comp_due[k] == mn + 1) m_inframe[k] = 1'b0;
                    if (m_idle && m_st) begin
                        m_inframe[k] = 1'b1; m_accept[k] = 1'b1; m_cnt[k] = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input int p1, input int p2, input int p3,
                           input int p4, input int p5, input int p6,
                           input int p7, input int p8, input int p9);
        win[0] = 8'(p1); win[1] = 8'(p2); win[2] = 8'(p3);
        win[3] = 8'(p4); win[4] = 8'(p5); win[5] = 8'(p6);
        win[6] = 8'(p7); win[7] = 8'(p8); win[8] = 8'(p9);
    endtask

    task automatic rand_win();
        for (int i = 0; i < 9; i++) win[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin : main
        n_checks = 0; n_fail = 0; chk_en = 1'b0; cyc = 0;
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0; win_valid = 1'b0;
        thr = 8'd20;
        set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pin the reference model against hand-computed values.
        chk("ref_flat", -1, 32'(sobel_ref(100,100,100,100,100,100,100,100,100)), 32'(EXP_FLAT));
        chk("ref_vert", -1, 32'(sobel_ref(0,0,255,0,0,255,0,0,255)), 32'(EXP_VERT));
        chk("ref_small", -1, 32'(sobel_ref(0,0,10,0,0,0,0,0,0)), 32'(EXP_SMALL));
        chk("ref_nine", -1, 32'(sobel_ref(0,0,9,0,0,0,0,0,0)), 32'(EXP_NINE));

        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_count", 1, 32'(pc[1]), 32'd0);
        chk("rst_busy", 1, 32'(bz[1]), 32'd0);

        // Flat window into the NUM_PIX=1 instance.
        tick(); start1 = 1'b1;
        tick(); start1 = 1'b0; set_win(100,100,100,100,100,100,100,100,100); win_valid = 1'b1;
        tick(); win_valid = 1'b0;
        tick();
        tick();
        chk("flat_valid", 0, 32'(pv[0]), 32'd1);
        chk("flat_out", 0, 32'(po[0]), 32'(EXP_FLAT));
        tick();
        chk("flat_complete", 0, 32'(cp[0]), 32'd1);
        chk("flat_count", 0, 32'(pc[0]), 32'd1);
        chk("flat_busy", 0, 32'(bz[0]), 32'd0);
        tick();

        // NUM_PIX=4 frame with gaps and a fifth window that must be ignored.
        tick(); start4 = 1'b1;
        tick(); start4 = 1'b0; set_win(0,0,255,0,0,255,0,0,255); win_valid = 1'b1;
        tick(); win_valid = 1'b0;
        tick(); set_win(0,0,10,0,0,0,0,0,0); win_valid = 1'b1;
        tick(); win_valid = 1'b0;
        chk("vert_valid", 1, 32'(pv[1]), 32'd1);
        chk("vert_out", 1, 32'(po[1]), 32'(EXP_VERT));
        tick(); set_win(0,0,9,0,0,0,0,0,0); win_valid = 1'b1;
        tick(); set_win(50,60,70,80,90,100,110,120,130);
        chk("small_out", 1, 32'(po[1]), 32'(EXP_SMALL));
        tick(); set_win(0,0,0,0,0,0,255,255,255);
        tick(); win_valid = 1'b0;
        chk("nine_out", 1, 32'(po[1]), 32'(EXP_NINE));
        tick();
        chk("frame_count", 1, 32'(pc[1]), 32'd4);
        chk("frame_busy", 1, 32'(bz[1]), 32'd1);
        tick();
        chk("frame_complete", 1, 32'(cp[1]), 32'd1);
        chk("frame_busy_low", 1, 32'(bz[1]), 32'd0);
        chk("fifth_ignored", 1, 32'(pv[1]), 32'd0);
        tick();
        chk("complete_once", 1, 32'(cp[1]), 32'd0);
        tick();

        // Reset one cycle after the second accepted window.
        tick(); start4 = 1'b1;
        tick(); start4 = 1'b0; rand_win(); win_valid = 1'b1;
        tick(); rand_win();
        tick(); win_valid = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; rand_win(); win_valid = 1'b1;
        chk("mid_rst_count", 1, 32'(pc[1]), 32'd0);
        chk("mid_rst_busy", 1, 32'(bz[1]), 32'd0);
        chk("mid_rst_valid", 1, 32'(pv[1]), 32'd0);
        tick(); rand_win();
        tick(); rand_win();
        tick(); win_valid = 1'b0;
        chk("idle_ignore_count", 1, 32'(pc[1]), 32'd0);
        chk("idle_ignore_valid", 1, 32'(pv[1]), 32'd0);
        tick();

        // Back-to-back random windows; start during RUN must be ignored.
        tick(); start1 = 1'b1; start4 = 1'b1; rand_win(); win_valid = 1'b1;
        tick(); start1 = 1'b0; start4 = 1'b0; rand_win();
        tick(); start4 = 1'b1; rand_win();
        tick(); start4 = 1'b0; rand_win();
        for (int i = 0; i < 3; i++) begin
            tick(); rand_win();
        end
        tick(); win_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("final_count4", 1, 32'(pc[1]), 32'd4);
        chk("final_count1", 0, 32'(pc[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_filter.md
Name: sobel_window_filter

Overview:
- Downstream stage of the 3x3 window generator; consumes its nine window pixels (out1..out9).
- Computes a pipelined Sobel gradient magnitude per window, one output pixel per accepted window.
- Counts output pixels per frame and signals frame completion, giving the image-processing top level a start/complete pair.

Parameters:
- NUM_PIX, default 100: accepted windows per frame; valid range 1..65535.
- CNT_W, default 16: width of pix_count; must hold NUM_PIX.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse; begins a frame when the block is idle.
- win_valid, input, 1: in1..in9 carry a valid window this cycle.
- in1..in9, input, 8 each: window pixels, row-major (in1 in2 in3 top row, in4 in5 in6 middle row, in7 in8 in9 bottom row); unsigned.
- threshold, input, 8: binarisation level; used only when SOBEL_THRESHOLD_EN is defined.
- pix_out, output, 8: filtered pixel.
- pix_valid, output, 1: pix_out is valid this cycle.
- busy, output, 1: high in RUN and DRAIN.
- complete, output, 1: one-cycle pulse at frame end.
- pix_count, output, CNT_W: windows accepted in the current frame.

Behaviour:
- Reset (synchronous, active-high):
  - pix_out=0, pix_valid=0, busy=0, complete=0, pix_count=0.
  - All pipeline valid bits cleared; FSM goes to IDLE.
  - Reset has priority over every other event, including mid-frame; in-flight results are discarded with no pix_valid.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start moves to RUN and clears pix_count. win_valid is ignored.
  - RUN: a window is accepted when win_valid=1, and pix_count increments.
    - The window that makes pix_count reach NUM_PIX moves the FSM to DRAIN the same cycle.
    - Windows beyond NUM_PIX are never accepted.
  - DRAIN: new windows are ignored. Move to DONE when all pipeline valid bits are 0.
  - DONE: complete=1 for exactly one cycle, then IDLE. pix_count holds its final value until the next start.
  - start in RUN, DRAIN or DONE is ignored.
- Pipeline: 3 register stages. Output latency is exactly 3 cycles from the accepting edge to pix_valid. No stalls; one window per cycle sustained.
  - S1: Gx = (in3 + 2*in6 + in9) - (in1 + 2*in4 + in7); Gy = (in7 + 2*in8 + in9) - (in1 + 2*in2 + in3). Both are signed 11-bit, range -1020..1020.
  - S2: |Gx| and |Gy|, unsigned 10-bit.
  - S3: sum = |Gx| + |Gy|, 11-bit. pix_out = 255 if sum > 255, else sum[7:0].
- pix_valid is the S3 valid bit. pix_out holds its last value when pix_valid=0.
- busy = (state==RUN) or (state==DRAIN).
- NUM_PIX=1: the first accepted window moves the FSM to DRAIN; complete fires 4 cycles after acceptance.

Optional Feature:
- Macro: SOBEL_THRESHOLD_EN.
  - Defined: S3 output is binarised. pix_out=255 if the saturated magnitude >= threshold, else 0. Latency is unchanged.
  - Undefined: the threshold input is unused and pix_out is the saturated magnitude.

Test Plan:
- Flat window, all in*=100, NUM_PIX=1 -> pix_out=0, pix_valid 3 cycles after acceptance; complete 1 cycle later; pix_count=1.
- Vertical edge: in1=in4=in7=0, in3=in6=in9=255, others 0 -> Gx=1020, Gy=0 -> pix_out=255 (saturation).
- Small gradient: in3=10, all others 0 -> Gx=10, Gy=-10 -> pix_out=20.
- NUM_PIX=4, windows on cycles with gaps, plus a 5th window after the 4th -> exactly 4 pix_valid pulses; 5th ignored; complete pulses once; busy falls with complete.
- Reset asserted 1 cycle after the 2nd accepted window of a NUM_PIX=4 frame -> no further pix_valid, pix_count=0, FSM idle; windows ignored until the next start.
- With SOBEL_THRESHOLD_EN, threshold=20: small-gradient window -> 255; in3=9 only (magnitude 18) -> 0.
